// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: stage enables, load-use stall, DM wait states, start/drain FSM.
// Outputs are combinational from state and inputs; a DM access at MEM freezes the pipe for MEM_WAIT cycles.
module pipe_hazard_ctrl #(
    parameter int MEM_WAIT  = 2,
    parameter int DRAIN_CYC = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic        i_halt,
    input  logic [4:0]  i_id_rs,
    input  logic [4:0]  i_id_rt,
    input  logic        i_id_use_rt,
    input  logic [4:0]  i_ex_rd,
    input  logic        i_ex_lw,
    input  logic        i_mem_dmwr,
    input  logic        i_mem_mtr,
    output logic        o_pc_en,
    output logic        o_ifid_en,
    output logic        o_idex_en,
    output logic        o_idex_flush,
    output logic        o_exmem_en,
    output logic        o_memwb_bubble,
    output logic        o_dm_wr,
    output logic        o_busy,
    output logic [1:0]  o_state,
    output logic [15:0] o_stall_cycles
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [3:0] LP_WAIT_M1  = (MEM_WAIT == 0) ? 4'd0 : 4'(MEM_WAIT - 1);
    localparam logic [3:0] LP_DRAIN_M1 = 4'(DRAIN_CYC - 1);
    localparam bit         LP_HAS_WAIT = (MEM_WAIT != 0);

    state_t      r_state;
    state_t      r_ret;
    logic [3:0]  r_wcnt;
    logic [3:0]  r_dcnt;
    logic        r_ack;
    logic [15:0] r_stall_cycles;

    logic w_access;
    logic w_memstall;
    logic w_luhaz;
    logic w_stall_inc;
    logic w_pc_en;
    logic w_ifid_en;
    logic w_idex_en;
    logic w_idex_flush;
    logic w_exmem_en;
    logic w_memwb_bubble;

    assign w_access   = i_mem_dmwr | i_mem_mtr;
    // ack marks an access whose wait states are already served, so it completes instead of stalling again
    assign w_memstall = (LP_HAS_WAIT && w_access && !r_ack &&
                         (r_state == ST_RUN || r_state == ST_DRAIN)) ||
                        (r_state == ST_WAIT);
    assign w_luhaz    = i_ex_lw && (i_ex_rd != 5'd0) &&
                        ((i_ex_rd == i_id_rs) || (i_id_use_rt && (i_ex_rd == i_id_rt)));
    assign w_stall_inc = w_memstall || ((r_state == ST_RUN) && w_luhaz);

    always_comb begin
        w_pc_en        = 1'b0;
        w_ifid_en      = 1'b0;
        w_idex_en      = 1'b0;
        w_idex_flush   = 1'b0;
        w_exmem_en     = 1'b0;
        w_memwb_bubble = 1'b0;
        if (w_memstall) begin
            w_memwb_bubble = 1'b1;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_luhaz) begin
                        w_idex_flush = 1'b1;
                        w_exmem_en   = 1'b1;
                    end else begin
                        w_pc_en    = 1'b1;
                        w_ifid_en  = 1'b1;
                        w_idex_en  = 1'b1;
                        w_exmem_en = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    w_idex_flush = 1'b1;
                    w_exmem_en   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_pc_en        = w_pc_en;
    assign o_ifid_en      = w_ifid_en;
    assign o_idex_en      = w_idex_en;
    assign o_idex_flush   = w_idex_flush;
    assign o_exmem_en     = w_exmem_en;
    assign o_memwb_bubble = w_memwb_bubble;
    assign o_dm_wr        = w_exmem_en & i_mem_dmwr;
    assign o_busy         = (r_state != ST_IDLE);
    assign o_state        = r_state;
    assign o_stall_cycles = r_stall_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_ret          <= ST_RUN;
            r_wcnt         <= 4'd0;
            r_dcnt         <= 4'd0;
            r_ack          <= 1'b0;
            r_stall_cycles <= 16'd0;
        end else begin
            if (w_exmem_en) begin
                r_ack <= 1'b0;
            end
            if (w_stall_inc && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state        <= ST_RUN;
                        r_stall_cycles <= 16'd0;
                    end
                end
                ST_WAIT: begin
                    if (r_wcnt == 4'd1) begin
                        r_ack   <= 1'b1;
                        r_state <= r_ret;
                    end else begin
                        r_wcnt <= r_wcnt - 4'd1;
                    end
                end
                default: begin
                    // the drain count lives in its own register so wait states freeze it
                    if (w_memstall) begin
                        r_wcnt <= LP_WAIT_M1;
                        if (MEM_WAIT == 1) begin
                            r_ack <= 1'b1;
                        end else begin
                            r_ret   <= r_state;
                            r_state <= ST_WAIT;
                        end
                    end else if (r_state == ST_RUN) begin
                        if (i_halt) begin
                            r_state <= ST_DRAIN;
                            r_dcnt  <= LP_DRAIN_M1;
                        end
                    end else begin
                        if (r_dcnt == 4'd0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_dcnt <= r_dcnt - 4'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: instance 0 uses MEM_WAIT=2, instance 1 MEM_WAIT=0, instance 2 MEM_WAIT=1; all share inputs.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, halt, use_rt, ex_lw, dmwr, mtr;
    logic [4:0] id_rs, id_rt, ex_rd;

    logic        pc_en[3];
    logic        ifid_en[3];
    logic        idex_en[3];
    logic        flush[3];
    logic        exmem_en[3];
    logic        bubble[3];
    logic        dm_wr[3];
    logic        busy[3];
    logic [1:0]  state[3];
    logic [15:0] stalls[3];

    int n_total = 0;
    int n_bad   = 0;
    int n_wr    = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_WAIT(2), .DRAIN_CYC(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_halt(halt),
        .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_use_rt(use_rt),
        .i_ex_rd(ex_rd), .i_ex_lw(ex_lw), .i_mem_dmwr(dmwr), .i_mem_mtr(mtr),
        .o_pc_en(pc_en[0]), .o_ifid_en(ifid_en[0]), .o_idex_en(idex_en[0]),
        .o_idex_flush(flush[0]), .o_exmem_en(exmem_en[0]), .o_memwb_bubble(bubble[0]),
        .o_dm_wr(dm_wr[0]), .o_busy(busy[0]), .o_state(state[0]), .o_stall_cycles(stalls[0])
    );

    pipe_hazard_ctrl #(.MEM_WAIT(0), .DRAIN_CYC(3)) u_dut_w0 (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_halt(halt),
        .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_use_rt(use_rt),
        .i_ex_rd(ex_rd), .i_ex_lw(ex_lw), .i_mem_dmwr(dmwr), .i_mem_mtr(mtr),
        .o_pc_en(pc_en[1]), .o_ifid_en(ifid_en[1]), .o_idex_en(idex_en[1]),
        .o_idex_flush(flush[1]), .o_exmem_en(exmem_en[1]), .o_memwb_bubble(bubble[1]),
        .o_dm_wr(dm_wr[1]), .o_busy(busy[1]), .o_state(state[1]), .o_stall_cycles(stalls[1])
    );

    pipe_hazard_ctrl #(.MEM_WAIT(1), .DRAIN_CYC(3)) u_dut_w1 (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_halt(halt),
        .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_use_rt(use_rt),
        .i_ex_rd(ex_rd), .i_ex_lw(ex_lw), .i_mem_dmwr(dmwr), .i_mem_mtr(mtr),
        .o_pc_en(pc_en[2]), .o_ifid_en(ifid_en[2]), .o_idex_en(idex_en[2]),
        .o_idex_flush(flush[2]), .o_exmem_en(exmem_en[2]), .o_memwb_bubble(bubble[2]),
        .o_dm_wr(dm_wr[2]), .o_busy(busy[2]), .o_state(state[2]), .o_stall_cycles(stalls[2])
    );

    // counts committed stores of the MEM_WAIT=2 instance, one per clock with the strobe high
    always @(negedge clk) begin
        if (dm_wr[0]) n_wr++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; halt = 1'b0; use_rt = 1'b0; ex_lw = 1'b0;
        dmwr = 1'b0; mtr = 1'b0; id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
        tick(); tick();
        chk("rst_state", 32'(state[0]), 0);
        chk("rst_busy", 32'(busy[0]), 0);
        chk("rst_pc_en", 32'(pc_en[0]), 0);
        chk("rst_exmem", 32'(exmem_en[0]), 0);
        chk("rst_stalls", 32'(stalls[0]), 0);

        rst_n = 1'b1;
        tick();
        start = 1'b1; settle();
        chk("idle_state", 32'(state[0]), 0);
        chk("idle_pc_en", 32'(pc_en[0]), 0);
        tick(); start = 1'b0; settle();
        chk("run_state", 32'(state[0]), 1);
        chk("run_enables", {28'd0, pc_en[0], ifid_en[0], idex_en[0], exmem_en[0]}, 32'hF);
        chk("run_flush_bub", {30'd0, flush[0], bubble[0]}, 0);
        chk("run_busy", 32'(busy[0]), 1);
        chk("run_stalls", 32'(stalls[0]), 0);

        // load-use on rs
        ex_lw = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; settle();
        chk("lu_rs_pc_en", 32'(pc_en[0]), 0);
        chk("lu_rs_ifid_idex", {30'd0, ifid_en[0], idex_en[0]}, 0);
        chk("lu_rs_flush", 32'(flush[0]), 1);
        chk("lu_rs_exmem", 32'(exmem_en[0]), 1);
        tick(); ex_lw = 1'b0; settle();
        chk("lu_rs_cnt", 32'(stalls[0]), 1);
        chk("lu_rs_clear", 32'(pc_en[0]), 1);
        // r0 destination never hazards
        ex_lw = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; settle();
        chk("lu_r0_pc_en", 32'(pc_en[0]), 1);
        tick();
        // rt match only counts when rt is read
        ex_rd = 5'd9; id_rs = 5'd3; id_rt = 5'd9; use_rt = 1'b0; settle();
        chk("lu_rt_unused", 32'(pc_en[0]), 1);
        tick();
        use_rt = 1'b1; settle();
        chk("lu_rt_used", 32'(flush[0]), 1);
        tick(); ex_lw = 1'b0; use_rt = 1'b0; settle();
        chk("lu_rt_cnt", 32'(stalls[0]), 2);

        // MEM_WAIT=2 store held until it commits
        dmwr = 1'b1; settle();
        chk("st_w1_state", 32'(state[0]), 1);
        chk("st_w1_exmem", 32'(exmem_en[0]), 0);
        chk("st_w1_bubble", 32'(bubble[0]), 1);
        chk("st_w1_dmwr", 32'(dm_wr[0]), 0);
        chk("st_w1_pc_en", 32'(pc_en[0]), 0);
        tick(); settle();
        chk("st_w2_state", 32'(state[0]), 2);
        chk("st_w2_exmem", 32'(exmem_en[0]), 0);
        chk("st_w2_dmwr", 32'(dm_wr[0]), 0);
        tick(); settle();
        chk("st_done_state", 32'(state[0]), 1);
        chk("st_done_dmwr", 32'(dm_wr[0]), 1);
        chk("st_done_exmem", 32'(exmem_en[0]), 1);
        chk("st_done_bubble", 32'(bubble[0]), 0);
        chk("st_done_cnt", 32'(stalls[0]), 4);
        tick(); dmwr = 1'b0; settle();
        chk("st_once", n_wr, 1);
        tick();

        // MEM_WAIT=0 store commits with no stall
        dmwr = 1'b1; settle();
        chk("w0_dmwr", 32'(dm_wr[1]), 1);
        chk("w0_exmem", 32'(exmem_en[1]), 1);
        chk("w0_bubble", 32'(bubble[1]), 0);
        tick(); dmwr = 1'b0;
        tick(); tick(); tick();

        // MEM_WAIT=1 load stalls one cycle without leaving RUN
        mtr = 1'b1; settle();
        chk("w1_c1_exmem", 32'(exmem_en[2]), 0);
        chk("w1_c1_bubble", 32'(bubble[2]), 1);
        chk("w1_c1_state", 32'(state[2]), 1);
        tick(); settle();
        chk("w1_c2_exmem", 32'(exmem_en[2]), 1);
        chk("w1_c2_state", 32'(state[2]), 1);
        tick(); mtr = 1'b0;
        tick(); tick(); tick();

        // halt and drain with a store arriving mid-drain
        halt = 1'b1; settle();
        chk("halt_state", 32'(state[0]), 1);
        chk("halt_pc_en", 32'(pc_en[0]), 1);
        tick(); halt = 1'b0; settle();
        chk("dr1_state", 32'(state[0]), 3);
        chk("dr1_pc_en", 32'(pc_en[0]), 0);
        chk("dr1_flush", 32'(flush[0]), 1);
        chk("dr1_exmem", 32'(exmem_en[0]), 1);
        tick(); dmwr = 1'b1; settle();
        chk("dr_stall_exmem", 32'(exmem_en[0]), 0);
        chk("dr_stall_bubble", 32'(bubble[0]), 1);
        chk("dr_stall_state", 32'(state[0]), 3);
        tick(); settle();
        chk("dr_wait_state", 32'(state[0]), 2);
        tick(); settle();
        chk("dr2_state", 32'(state[0]), 3);
        chk("dr2_dmwr", 32'(dm_wr[0]), 1);
        tick(); dmwr = 1'b0; settle();
        chk("dr3_state", 32'(state[0]), 3);
        chk("dr3_busy", 32'(busy[0]), 1);
        tick(); settle();
        chk("dr_end_state", 32'(state[0]), 0);
        chk("dr_end_busy", 32'(busy[0]), 0);
        chk("dr_end_wr", n_wr, 2);

        // reset in the middle of WAIT drops the pending store
        start = 1'b1;
        tick(); start = 1'b0; dmwr = 1'b1; settle();
        chk("rw_stall", 32'(state[0]), 1);
        tick(); settle();
        chk("rw_wait", 32'(state[0]), 2);
        rst_n = 1'b0; settle();
        chk("rw_rst_state", 32'(state[0]), 0);
        chk("rw_rst_dmwr", 32'(dm_wr[0]), 0);
        chk("rw_rst_bubble", 32'(bubble[0]), 0);
        chk("rw_rst_busy", 32'(busy[0]), 0);
        tick(); settle();
        chk("rw_rst_dmwr2", 32'(dm_wr[0]), 0);
        rst_n = 1'b1; start = 1'b1; settle();
        chk("rw_idle_dmwr", 32'(dm_wr[0]), 0);
        tick(); start = 1'b0; settle();
        chk("rw_restall_state", 32'(state[0]), 1);
        chk("rw_restall_dmwr", 32'(dm_wr[0]), 0);
        chk("rw_restall_exmem", 32'(exmem_en[0]), 0);
        tick(); tick(); settle();
        chk("rw_commit", 32'(dm_wr[0]), 1);
        tick(); dmwr = 1'b0; settle();
        chk("rw_total_wr", n_wr, 3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage MIPS32 datapath. It issues the load/flush enables for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It detects load-use hazards, stalls the whole pipeline for data-memory wait states on accesses in the MEM stage, and gates the DM write strobe so that each store commits exactly once. It also runs the start and halt (drain) sequence.

Parameters:
MEM_WAIT, 2, stall cycles per DM access presented at MEM; 0 means no stall (range 0..15)
DRAIN_CYC, 3, non-stalled bubble cycles needed to empty the pipeline on halt (range 1..15)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
i_start  input  1  run request, sampled only in IDLE
i_halt  input  1  level halt request
i_id_rs  input  5  rs of the instruction in ID
i_id_rt  input  5  rt of the instruction in ID
i_id_use_rt  input  1  the ID instruction reads rt
i_ex_rd  input  5  destination of the instruction in EX
i_ex_lw  input  1  the EX instruction is a load
i_mem_dmwr  input  1  DMWR from EX/MEM
i_mem_mtr  input  1  MTR from EX/MEM (load at MEM)
o_pc_en  output  1  PC load enable
o_ifid_en  output  1  IF/ID load enable
o_idex_en  output  1  ID/EX load enable
o_idex_flush  output  1  load a bubble (all control zero) into ID/EX
o_exmem_en  output  1  EX/MEM load enable
o_memwb_bubble  output  1  load a bubble into MEM/WB
o_dm_wr  output  1  gated data-memory write strobe
o_busy  output  1  state is not IDLE
o_state  output  2  0=IDLE 1=RUN 2=WAIT 3=DRAIN
o_stall_cycles  output  16  saturating count of stall cycles

Behaviour:
- One clock domain: clk. Reset is asynchronous, active-low (rst_n).
- Reset forces: state=IDLE, cnt=0, ack=0, o_stall_cycles=0. Resulting outputs are all 0, with o_state=0. A store pending at reset is never strobed.
- Internal signals:
  - access = i_mem_dmwr | i_mem_mtr.
  - memstall = MEM_WAIT≠0 & access & !ack & state∈{RUN,DRAIN}, or state==WAIT.
  - luhaz = i_ex_lw & i_ex_rd≠0 & (i_ex_rd==i_id_rs | (i_id_use_rt & i_ex_rd==i_id_rt)).
- Outputs are combinational from state, registers and inputs.
- IDLE:
  - All enables are 0.
  - i_start=1 → RUN next cycle; o_stall_cycles is cleared on this transition.
- Memory stall (highest priority; applies in RUN, WAIT and DRAIN):
  - o_pc_en, o_ifid_en, o_idex_en and o_exmem_en are 0; o_idex_flush=0; o_memwb_bubble=1; o_dm_wr=0.
  - First stall cycle (in RUN or DRAIN): cnt←MEM_WAIT-1. If MEM_WAIT==1, set ack←1 and stay in the current state. Otherwise remember the return state and go to WAIT.
  - WAIT: if cnt==1, set ack←1 and return to the saved state; else cnt←cnt-1.
  - Total stall is exactly MEM_WAIT cycles per access.
  - If access deasserts during WAIT (not legal, because registers are frozen), WAIT still completes.
- Access completion: the first cycle with access and not memstall.
  - The pipeline advances and o_dm_wr=i_mem_dmwr.
  - ack clears on every cycle with o_exmem_en=1.
- RUN without memstall:
  - luhaz=1: o_pc_en=0, o_ifid_en=0, o_idex_en=0, o_idex_flush=1, o_exmem_en=1, o_memwb_bubble=0. This lasts one cycle; the hazard clears once the load moves to MEM.
  - Otherwise all enables are 1 and flush/bubble are 0.
  - i_halt=1 → DRAIN with cnt←DRAIN_CYC-1. That cycle's outputs still follow the RUN rules above.
- DRAIN without memstall:
  - o_pc_en=0, o_ifid_en=0, o_idex_flush=1, o_exmem_en=1.
  - If cnt==0 → IDLE; else cnt←cnt-1.
  - Memory stalls inside DRAIN freeze the drain count.
- i_start outside IDLE is ignored. i_halt is ignored in IDLE and WAIT.
- o_stall_cycles increments on each cycle with memstall or (RUN & luhaz), and saturates at 0xFFFF.
- A reset asserted at any point returns to IDLE within the same cycle (asynchronous).

Test Plan:
- Reset then i_start pulse → o_state 0→1; next cycle all enables =1, o_busy=1, o_stall_cycles=0.
- RUN with i_ex_lw=1, i_ex_rd=8, i_id_rs=8 for one cycle → exactly one cycle with o_pc_en=0, o_idex_flush=1, o_exmem_en=1; count becomes 1. Repeat with i_ex_rd=0 → no stall.
- MEM_WAIT=2, i_mem_dmwr=1 held → two cycles of o_exmem_en=0, o_memwb_bubble=1, o_dm_wr=0 (state goes 1 then 2); third cycle o_dm_wr=1 and o_exmem_en=1; o_dm_wr is never asserted twice.
- MEM_WAIT=0 store → o_dm_wr=1 in the same cycle, no stall. MEM_WAIT=1 load → one stall cycle, state stays RUN.
- i_halt in RUN with DRAIN_CYC=3, plus an access at MEM during drain → DRAIN lasts 3 non-stalled cycles plus MEM_WAIT stall cycles, then IDLE, o_busy=0.
- rst_n low mid-WAIT → outputs are zero immediately and the store is never strobed; i_start afterwards resumes normally with ack=0.
